// File: rtl/serial_bus_pkg.sv
// Shared FSM states, CRC polynomial and frame-length helper
// for the serial bus transmitter.
package serial_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_e;

    // x^4 + x + 1, with the x^4 term implied
    localparam logic [3:0] CRC_POLY = 4'h3;

    function automatic int frame_len(
        input int addr_w,
        input int data_w,
        input int crc_w
    );
        return 2 + 2 * addr_w + data_w + crc_w;
    endfunction

    function automatic logic [3:0] crc4_step(
        input logic [3:0] crc,
        input logic       b
    );
        return {crc[2:0], 1'b0} ^ ((crc[3] ^ b) ? CRC_POLY : 4'h0);
    endfunction

endpackage

// File: rtl/serial_bus_tx_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, and the pointer moves
// past the winner only on an accepted grant.
module rr_arbiter #(
    parameter int N  = 16,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic          accept,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          req_any
);
    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin
        logic [IW-1:0] k;
        grant     = '0;
        grant_idx = '0;
        req_any   = 1'b0;
        k         = '0;
        for (int i = 0; i < N; i++) begin
            k = IW'((int'(ptr_q) + i) % N);
            if (!req_any && req[k]) begin
                req_any   = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = k;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept && req_any) begin
            ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/serial_bus_tx_arbiter.sv
// Round-robin multi-channel serial frame transmitter.
// Define SERIAL_BUS_CRC_GEN_EN to generate the CRC field in hardware.
module serial_bus_tx_arbiter
    import serial_bus_pkg::*;
#(
    parameter int N_CH   = 16,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4,
    parameter int CRC_W  = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [N_CH-1:0]        ch_enable,
    input  logic [N_CH-1:0]        req_valid,
    output logic [N_CH-1:0]        req_ready,
    input  logic [N_CH*DATA_W-1:0] req_data,
    input  logic [N_CH*ADDR_W-1:0] req_addr,
    input  logic [N_CH*CRC_W-1:0]  req_crc,
    output logic                   bus_out,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int FL = frame_len(ADDR_W, DATA_W, CRC_W);
    localparam int CW = $clog2(FL);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FL-1:0]     sh_q, sh_d;
    logic [N_CH-1:0]   grant;
    logic [IW-1:0]     grant_idx;
    logic              req_any;
    logic              accept;
    logic [DATA_W-1:0] data_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [CRC_W-1:0]  crc_sel;

    assign accept = (state_q == IDLE) && req_any && reset_n;

    rr_arbiter #(
        .N  (N_CH),
        .IW (IW)
    ) u_arb (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req_valid & ch_enable),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .req_any   (req_any)
    );

    assign req_ready  = accept ? grant : '0;
    assign busy       = (state_q == SEND);
    assign frame_done = (state_q == GAP);

    assign data_sel = req_data[int'(grant_idx)*DATA_W +: DATA_W];
    assign addr_sel = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];

`ifdef SERIAL_BUS_CRC_GEN_EN
    localparam int CRC_LO = 1 + 2 * ADDR_W + DATA_W;

    logic [CRC_W-1:0] crc_q, crc_d;
    logic             in_crc;

    // The CRC slot in the shift register stays zero; crc_q fills it.
    assign crc_sel = '0;
    assign in_crc  = (cnt_q >= CW'(CRC_LO)) &&
                     (cnt_q < CW'(CRC_LO + CRC_W));

    always_comb begin
        crc_d = crc_q;
        if (accept) begin
            crc_d = '0;
        end else if (state_q == SEND) begin
            if (in_crc) begin
                crc_d = crc_q << 1;
            end else if (cnt_q != '0 && cnt_q < CW'(CRC_LO)) begin
                crc_d = crc4_step(crc_q, sh_q[FL-1]);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign bus_out = (state_q == SEND) &&
                     (in_crc ? crc_q[CRC_W-1] : sh_q[FL-1]);
`else
    assign crc_sel = req_crc[int'(grant_idx)*CRC_W +: CRC_W];
    assign bus_out = (state_q == SEND) && sh_q[FL-1];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    sh_d    = {1'b1, ADDR_W'(grant_idx), addr_sel,
                               data_sel, crc_sel, 1'b0};
                end
            end
            SEND: begin
                sh_d = sh_q << 1;
                if (cnt_q == CW'(FL - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

endmodule

// File: tb/tb_serial_bus_tx_arbiter.sv
// Bench for serial_bus_tx_arbiter: default build and a small 4-channel
// build, checked every cycle against a frame-level behavioural model.
module tb_serial_bus_tx_arbiter;
    localparam int NA = 16, DA = 64, AA = 4, CA = 4;
    localparam int NB = 4, DB = 8, AB = 2;
`ifdef SERIAL_BUS_CRC_GEN_EN
    localparam int CB = 4;
`else
    localparam int CB = 2;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b1;

    logic [NA-1:0]    en_a = '0, val_a = '0, rdy_a;
    logic [NA*DA-1:0] dat_a = '0;
    logic [NA*AA-1:0] adr_a = '0;
    logic [NA*CA-1:0] crc_a = '0;
    logic             bus_a, busy_a, fd_a;

    logic [NB-1:0]    en_b = '0, val_b = '0, rdy_b;
    logic [NB*DB-1:0] dat_b = '0;
    logic [NB*AB-1:0] adr_b = '0;
    logic [NB*CB-1:0] crc_b = '0;
    logic             bus_b, busy_b, fd_b;

    int n_tests = 0;
    int n_fail = 0;
    int cyc_n = 0;

    serial_bus_tx_arbiter u_dut_a (
        .clock(clock), .reset_n(reset_n), .ch_enable(en_a),
        .req_valid(val_a), .req_ready(rdy_a), .req_data(dat_a),
        .req_addr(adr_a), .req_crc(crc_a), .bus_out(bus_a),
        .busy(busy_a), .frame_done(fd_a)
    );

    serial_bus_tx_arbiter #(
        .N_CH(NB), .DATA_W(DB), .ADDR_W(AB), .CRC_W(CB)
    ) u_dut_b (
        .clock(clock), .reset_n(reset_n), .ch_enable(en_b),
        .req_valid(val_b), .req_ready(rdy_b), .req_data(dat_b),
        .req_addr(adr_b), .req_crc(crc_b), .bus_out(bus_b),
        .busy(busy_b), .frame_done(fd_b)
    );

    initial forever #5 clock = ~clock;

    // model state per DUT: bit position in frame (-1 none), gap flag, rr pointer
    int            m_pos[2] = '{-1, -1};
    bit            m_gap[2] = '{1'b0, 1'b0};
    int            m_ptr[2] = '{0, 0};
    logic [127:0]  m_frame[2];

    function automatic int pn(int d); return d ? NB : NA; endfunction
    function automatic int pa(int d); return d ? AB : AA; endfunction
    function automatic int pd(int d); return d ? DB : DA; endfunction
    function automatic int pc(int d); return d ? CB : CA; endfunction
    function automatic int fl(int d);
        return 2 + 2 * pa(d) + pd(d) + pc(d);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_frame(int d, int src,
        logic [63:0] dv, logic [3:0] av, logic [3:0] cv);
        logic [127:0] v;
        int a, dw, cw;
        a  = pa(d);
        dw = pd(d);
        cw = pc(d);
        v = 128'd1;
        v = (v << a) | 128'(src);
        v = (v << a) | 128'(av);
        v = (v << dw) | 128'(dv);
`ifdef SERIAL_BUS_CRC_GEN_EN
        begin
            logic [3:0] c;
            c = 4'h0;
            for (int p = 2 * a + dw - 1; p >= 0; p--) begin
                c = {c[2:0], 1'b0} ^ ((c[3] ^ v[p]) ? 4'h3 : 4'h0);
            end
            v = (v << 4) | 128'(c);
        end
`else
        v = (v << cw) | (128'(cv) & ((128'd1 << cw) - 128'd1));
`endif
        v = v << 1;
        return v;
    endfunction

    function automatic void fields(int d, int ch, output logic [63:0] dv,
        output logic [3:0] av, output logic [3:0] cv);
        if (d == 0) begin
            dv = dat_a[ch*DA +: DA];
            av = adr_a[ch*AA +: AA];
            cv = crc_a[ch*CA +: CA];
        end else begin
            dv = 64'(dat_b[ch*DB +: DB]);
            av = 4'(adr_b[ch*AB +: AB]);
            cv = 4'(crc_b[ch*CB +: CB]);
        end
    endfunction

    function automatic int winner(int d);
        logic [31:0] e;
        e = d ? 32'(val_b & en_b) : 32'(val_a & en_a);
        for (int i = 0; i < pn(d); i++) begin
            int k;
            k = (m_ptr[d] + i) % pn(d);
            if (e[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pos[d] = -1;
            m_gap[d] = 1'b0;
            m_ptr[d] = 0;
        end
    endtask

    task automatic step(int d);
        int w;
        logic [63:0] dv;
        logic [3:0] av, cv;
        if (!reset_n) begin
            m_pos[d] = -1;
            m_gap[d] = 1'b0;
            m_ptr[d] = 0;
        end else if (m_pos[d] >= 0) begin
            if (m_pos[d] == fl(d) - 1) begin
                m_pos[d] = -1;
                m_gap[d] = 1'b1;
            end else begin
                m_pos[d]++;
            end
        end else if (m_gap[d]) begin
            m_gap[d] = 1'b0;
        end else begin
            w = winner(d);
            if (w >= 0) begin
                fields(d, w, dv, av, cv);
                m_frame[d] = mk_frame(d, w, dv, av, cv);
                m_pos[d] = 0;
                m_ptr[d] = (w + 1) % pn(d);
            end
        end
    endtask

    initial forever begin
        @(posedge clock);
        cyc_n++;
        for (int d = 0; d < 2; d++) step(d);
    end

    // every-cycle comparison of all outputs against the model
    initial forever begin
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            string pfx;
            int w;
            logic [127:0] er;
            pfx = d ? "b" : "a";
            w = winner(d);
            er = (reset_n && m_pos[d] < 0 && !m_gap[d] && w >= 0)
                 ? (128'd1 << w) : 128'd0;
            chk({pfx, "_bus"}, d ? bus_b : bus_a,
                m_pos[d] >= 0 ? m_frame[d][fl(d) - 1 - m_pos[d]] : 1'b0);
            chk({pfx, "_busy"}, d ? busy_b : busy_a, m_pos[d] >= 0);
            chk({pfx, "_done"}, d ? fd_b : fd_a, m_gap[d]);
            chk({pfx, "_ready"}, d ? 128'(rdy_b) : 128'(rdy_a), er);
        end
    end

    task automatic wait_rdy(input int d, input int ch, output bit ok);
        logic [31:0] rv;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            rv = d ? 32'(rdy_b) : 32'(rdy_a);
            if (rv[ch]) begin
                ok = 1'b1;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_ready d=%0d ch=%0d: no grant in 400 cycles, expected one",
                 d, ch);
    endtask

    task automatic wait_any(output int idx, output int t);
        idx = -1;
        t = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (rdy_a != '0) begin
                for (int k = 0; k < NA; k++) if (rdy_a[k]) idx = k;
                t = cyc_n;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_any: no grant in 400 cycles, expected one");
    endtask

    task automatic rec_frame(input int d, input int ch,
                             output logic [127:0] v);
        bit ok;
        v = '0;
        wait_rdy(d, ch, ok);
        @(posedge clock);
        #1;
        if (d == 0) val_a[ch] = 1'b0;
        else val_b[ch] = 1'b0;
        for (int k = 0; k < fl(d); k++) begin
            @(negedge clock);
            v = (v << 1) | 128'(d ? bus_b : bus_a);
        end
        @(negedge clock);
        chk(d ? "b_done_after_fl" : "a_done_after_fl", d ? fd_b : fd_a, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2 reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    logic [127:0] v, e;
    int gi, gt, pt;
    int order[3] = '{0, 3, 15};

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_bus", bus_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", fd_a, 1'b0);
        chk("rst_ready", rdy_a, 0);
        #1 reset_n = 1'b1;

        // single channel 0 frame, and model pinned to literals
        e = '0;
        e[77] = 1'b1;
        e[69] = 1'b1;
        e[5] = 1'b1;
        e[1] = 1'b1;
`ifndef SERIAL_BUS_CRC_GEN_EN
        chk("model_pin_a", mk_frame(0, 0, 64'd1, 4'd1, 4'd1), e);
        chk("model_pin_b", mk_frame(1, 2, 64'hA5, 4'd3, 4'd2), 128'hDD2C);
`endif
        idle(1);
        en_a = 16'h0001;
        dat_a[63:0] = 64'd1;
        adr_a[3:0] = 4'd1;
        crc_a[3:0] = 4'd1;
        val_a[0] = 1'b1;
        rec_frame(0, 0, v);
`ifndef SERIAL_BUS_CRC_GEN_EN
        chk("t1_frame_bits", v, e);
`endif

        // round robin over 0, 3, 15 with frames 80 cycles apart
        do_reset();
        idle(1);
        en_a = '1;
        for (int c = 0; c < NA; c++) dat_a[c*DA +: DA] = {$urandom, $urandom};
        val_a = 16'h8009;
        pt = 0;
        for (int g = 0; g < 6; g++) begin
            wait_any(gi, gt);
            chk($sformatf("rr_order_%0d", g), gi, order[g % 3]);
            if (g > 0) chk($sformatf("rr_spacing_%0d", g), gt - pt, 80);
            pt = gt;
        end
        @(posedge clock);
        #1 val_a = '0;
        idle(85);

        // disabled channel never wins until enabled
        en_a = '0;
        val_a = 16'h0004;
        repeat (20) @(negedge clock);
        chk("dis_no_ready", rdy_a, 0);
        chk("dis_bus_low", bus_a, 1'b0);
        @(posedge clock);
        #1 en_a = 16'h0004;
        @(negedge clock);
        chk("en_ready_ch2", rdy_a, 16'h0004);
        @(posedge clock);
        #1 val_a = '0;
        @(negedge clock);
        chk("en_busy_next", busy_a, 1'b1);
        idle(85);

        // reset at bit 30 truncates the frame
        en_a = '1;
        val_a = 16'h0080;
        begin
            bit ok;
            wait_rdy(0, 7, ok);
        end
        @(posedge clock);
        #1 val_a = '0;
        repeat (30) @(posedge clock);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_bus", bus_a, 1'b0);
        chk("midrst_busy", busy_a, 1'b0);
        chk("midrst_done", fd_a, 1'b0);
        val_a = 16'h0021;
        repeat (3) @(negedge clock);
        #1 reset_n = 1'b1;
        #1 chk("midrst_ch0_wins", rdy_a, 16'h0001);
        @(posedge clock);
        #1 val_a = '0;
        @(negedge clock);
        chk("midrst_busy_next", busy_a, 1'b1);
        idle(85);

        // small configuration frame: channel 2 to addr 3, data A5
        en_b = '1;
        dat_b[2*DB +: DB] = 8'hA5;
        adr_b[2*AB +: AB] = 2'b11;
        crc_b[2*CB +: CB] = CB'(2);
        val_b = 4'b0100;
        rec_frame(1, 2, v);
`ifndef SERIAL_BUS_CRC_GEN_EN
        chk("small_frame_bits", v, 128'hDD2C);
`endif

`ifdef SERIAL_BUS_CRC_GEN_EN
        en_a = '1;
        dat_a[63:0] = '0;
        adr_a[3:0] = '0;
        crc_a[3:0] = 4'hF;
        val_a = 16'h0001;
        rec_frame(0, 0, v);
        chk("crc_zero", v[4:1], 4'h0);
        idle(2);
        dat_a[127:64] = 64'd1;
        adr_a[7:4] = 4'd1;
        crc_a[7:4] = 4'hF;
        val_a = 16'h0002;
        rec_frame(0, 1, v);
        e = mk_frame(0, 1, 64'd1, 4'd1, 4'hF);
        chk("crc_model", v[4:1], e[4:1]);
        chk("crc_not_req", v[4:1] != 4'hF, 1'b1);
        idle(2);
`endif

        // randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock);
            #1;
            if ($urandom_range(0, 15) == 0) begin
                en_a = 16'($urandom);
                en_b = 4'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                val_a = 16'($urandom);
                val_b = 4'($urandom);
            end
            if ($urandom_range(0, 31) == 0) begin
                for (int k = 0; k < NA; k++) begin
                    dat_a[k*DA +: DA] = {$urandom, $urandom};
                    adr_a[k*AA +: AA] = AA'($urandom);
                    crc_a[k*CA +: CA] = CA'($urandom);
                end
                for (int k = 0; k < NB; k++) begin
                    dat_b[k*DB +: DB] = DB'($urandom);
                    adr_b[k*AB +: AB] = AB'($urandom);
                    crc_b[k*CB +: CB] = CB'($urandom);
                end
            end
            if (c == 1500) begin
                reset_n = 1'b0;
                model_reset();
            end
            if (c == 1503) reset_n = 1'b1;
        end

        val_a = '0;
        val_b = '0;
        idle(100);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_bus_tx_arbiter.md
SERIAL_BUS_TX_ARBITER -- requirements
Module: serial_bus_tx_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 16, number of sender channels (2..32).
REQ-002 SHALL have parameter DATA_W, default 64, payload width per channel.
REQ-003 SHALL have parameter ADDR_W, default 4, address width; ADDR_W >= clog2(N_CH).
REQ-004 SHALL have parameter CRC_W, default 4, CRC field width.
REQ-005 SHALL use one clock and an asynchronous active-low reset: port clock (input, 1 bit, rising-edge), then reset_n (input, 1 bit, asynchronous, active-low).
REQ-006 SHALL have port ch_enable, input, N_CH bits, per-channel enable mask.
REQ-007 SHALL have port req_valid, input, N_CH bits, per-channel frame request.
REQ-008 SHALL have port req_ready, output, N_CH bits, one-hot capture acknowledge.
REQ-009 SHALL have port req_data, input, N_CH*DATA_W bits, packed payloads with channel i at [i*DATA_W +: DATA_W].
REQ-010 SHALL have port req_addr, input, N_CH*ADDR_W bits, packed receiver addresses.
REQ-011 SHALL have port req_crc, input, N_CH*CRC_W bits, packed sender-supplied CRCs.
REQ-012 SHALL have port bus_out, output, 1 bit, serial bus line.
REQ-013 SHALL have port busy, output, 1 bit, high while a frame is on the line.
REQ-014 SHALL have port frame_done, output, 1 bit, one-cycle pulse after the stop bit.

Function
REQ-015 SHALL make a channel eligible only when req_valid[i] and ch_enable[i] are both 1.
REQ-016 SHALL use an FSM with states IDLE, SEND and GAP.
REQ-017 SHALL, in IDLE with at least one eligible channel, grant exactly one channel by round-robin, starting from the channel after the last granted one.
REQ-018 SHALL, on grant, drive req_ready of the winner high for exactly the capture cycle, capture its fields on that edge, and move to SEND.
REQ-019 SHALL keep req_ready all-zero in SEND and GAP.
REQ-020 SHALL require the sender to hold req_valid and its fields stable until acceptance; the block does not check this.
REQ-021 SHALL send the frame MSB-first, one bit per clock, starting the cycle after capture.
REQ-022 SHALL use the frame order: start bit 1, source channel index (ADDR_W bits), receiver address (ADDR_W), data (DATA_W), CRC (CRC_W), stop bit 0.
REQ-023 SHALL have frame length FL = 2 + 2*ADDR_W + DATA_W + CRC_W, which is 78 bits at default parameters.
REQ-024 SHALL track the frame with a bit counter 0..FL-1 and leave SEND when the counter reaches FL-1.
REQ-025 SHALL go to GAP for exactly one cycle after the stop bit, with bus_out 0 and frame_done 1, then return to IDLE.
REQ-026 SHALL allow back-to-back frames to start at most 2 cycles apart: one GAP cycle, then one IDLE/capture cycle.
REQ-027 SHALL hold busy high in SEND and low otherwise; bus_out SHALL be 0 in IDLE.
REQ-028 SHALL let a ch_enable or req_valid change during SEND leave the frame in progress unaffected; the change affects only the next arbitration.
REQ-029 SHALL, when no channel is eligible, stay in IDLE and leave the round-robin pointer unchanged.

Reset
REQ-030 SHALL, on reset_n low, immediately force state IDLE, bus_out 0, busy 0, frame_done 0, req_ready 0, bit counter 0, and round-robin pointer so that channel 0 has highest priority.
REQ-031 SHALL, on reset mid-frame, truncate the frame with no stop bit and no frame_done pulse.
REQ-032 SHALL take the first arbitration after reset_n deasserts on the first clock edge that follows.

Configuration
REQ-033 SHALL use macro SERIAL_BUS_CRC_GEN_EN to select the CRC source.
REQ-034 SHALL, with SERIAL_BUS_CRC_GEN_EN defined, send in the CRC field a CRC computed serially over the source, address and data bits, with polynomial x^4+x+1, init 0, MSB-first, and ignore req_crc; CRC_W must be 4 in this mode.
REQ-035 SHALL, with SERIAL_BUS_CRC_GEN_EN undefined, send the captured req_crc verbatim and include no CRC logic.

Structure
REQ-036 SHALL put the FSM state enum, the CRC polynomial constant and an FL-calculation function in shared package serial_bus_pkg.
REQ-037 SHALL use one sub-module rr_arbiter (N_CH-bit request in, one-hot grant out, pointer update on accept).

Verification
REQ-038 SHALL cover: ch_enable=0x0001, req_valid[0]=1, data=1, addr=1, crc=1, macro undefined -> 78 bits 1,0000,0001,{63x0,1},0001,0; frame_done 78 cycles after req_ready[0].
REQ-039 SHALL cover: channels 0, 3 and 15 valid and held, all enabled -> grant order 0, 3, 15, 0, ...; consecutive start bits 80 cycles apart.
REQ-040 SHALL cover: req_valid[2]=1 with ch_enable[2]=0 -> no grant, bus_out stays 0; setting ch_enable[2]=1 -> grant on the next edge.
REQ-041 SHALL cover: reset_n pulled low at bit 30 of a frame -> bus_out 0 and busy 0 immediately, no frame_done; after release channel 0 wins over channel 5.
REQ-042 SHALL cover: macro defined, data=0, addr=0, source 0 -> CRC field 0000; data=1, addr=1, source 1 -> CRC matches the reference model and differs from req_crc.
REQ-043 SHALL cover: N_CH=4, DATA_W=8, ADDR_W=2 -> FL=16; a frame from channel 2 to addr 3 with data 0xA5 is serialised correctly.
